ddma_send_arbiter: RTL and testbench
====================================

# ddma_send_arbiter

Round-robin arbiter and sequencer that shares the PE's single DDMA send channel among `NUM_REQ` requesters, such as the CPU MMIO path and hardware agents. The block sits between the requesters and the DDMA send-side registers (dest/addr/size/cmd). It latches one request's descriptor, drives the send command, and waits for the DDMA acknowledge and return to idle. It then reports completion to the owning requester.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `MEMORY_WIDTH`, 32, descriptor word width
- `TIMEOUT_CYCLES`, 65535, watchdog limit; used only with `DDMA_ARB_TIMEOUT_EN`

Ports:
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `req_valid_in`  in  NUM_REQ  per-requester request, level
- `req_dest_in`  in  NUM_REQ×MEMORY_WIDTH  packed destination addresses
- `req_addr_in`  in  NUM_REQ×MEMORY_WIDTH  packed source RAM addresses
- `req_size_in`  in  NUM_REQ×MEMORY_WIDTH  packed sizes in bytes
- `req_grant_out`  out  NUM_REQ  one-hot, 1-cycle pulse when the descriptor is latched
- `req_done_out`  out  NUM_REQ  one-hot, 1-cycle pulse on completion
- `req_error_out`  out  NUM_REQ  one-hot, 1-cycle pulse on watchdog expiry
- `send_dest_out`, `send_addr_out`, `send_size_out`  out  MEMORY_WIDTH  latched descriptor to DDMA
- `send_cmd_out`  out  1  send command, level
- `send_busy_in`  in  1  DDMA send engine not idle
- `send_ack_in`  in  1  DDMA send-acknowledge (`irq_send`)
- `owner_out`  out  $clog2(NUM_REQ)  index of current or last granted requester
- `busy_out`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, RELEASE.
- **IDLE**
  - If any `req_valid_in` is high, select the first valid requester searching from `last_owner+1` with wrap to 0.
  - Latch that requester's dest/addr/size into `send_*_out`, set `owner_out`, and pulse `req_grant_out[owner]`.
  - If the latched size ≠ 0, go to ISSUE with `send_cmd_out`=1.
  - If the latched size = 0, skip the DDMA entirely: pulse `req_done_out` on the cycle after the grant and stay in IDLE. `send_cmd_out` never rises.
- **ISSUE**
  - Hold `send_cmd_out`=1 and keep the descriptor stable.
  - On `send_ack_in`=1, clear `send_cmd_out` and go to RELEASE.
  - `send_busy_in` need not have been observed high first.
- **RELEASE**
  - Wait until `send_ack_in`=0 and `send_busy_in`=0.
  - Then pulse `req_done_out[owner]`, set `last_owner`=owner, and go to IDLE.
- Round-robin pointer:
  - `last_owner` resets to NUM_REQ-1, so requester 0 has first priority after reset.
  - The pointer updates on done and on error.
- Requester obligations:
  - Hold valid and descriptor stable until grant.
  - Deassert valid on the cycle after grant unless another transfer is wanted.
  - A valid still high in the done cycle is a new request.
- Requesters' valid changes during ISSUE/RELEASE are ignored; the descriptor is already latched.
- Reset values: all outputs 0, `owner_out`=0, state IDLE. The descriptor registers are cleared.
- Reset asserted mid-operation:
  - `send_cmd_out` drops asynchronously.
  - No done or error pulse is issued.
  - The in-flight transfer is abandoned; the DDMA is reset by the same PE reset.

## Timing
- Valid sampled at edge N in IDLE → at edge N: grant pulse, `send_*_out` updated, `send_cmd_out`=1.
- Latency from valid to cmd is 1 cycle (registered).
- `send_ack_in` sampled high at edge M → `send_cmd_out`=0 after edge M.
- Ack and busy sampled low at edge K in RELEASE → done pulse during cycle K..K+1. The FSM is in IDLE in that cycle, so the earliest next grant is at edge K+1.
- Back-to-back throughput: one transfer per (DDMA duration + 2) cycles minimum.
- At most one of grant/done/error is asserted for a given requester per cycle. Grant and done never coincide except in the size-0 case, where done follows grant by 1 cycle.

## Configuration
- `DDMA_ARB_TIMEOUT_EN` defined:
  - A 32-bit watchdog counter clears on entry to ISSUE and increments each cycle in ISSUE or RELEASE.
  - When it reaches `TIMEOUT_CYCLES`: drop `send_cmd_out`, pulse `req_error_out[owner]` with no done pulse, update `last_owner`, and return to IDLE.
- `DDMA_ARB_TIMEOUT_EN` undefined:
  - No counter is built and `req_error_out` is tied to 0.
  - ISSUE/RELEASE wait indefinitely.

## Test plan
- **Single request:** req 0, dest 0x0101, addr 0x40000100, size 16; DDMA busy at +2, ack 1 cycle at +10, busy low at +11.
  - Grant[0] 1 cycle after valid.
  - `send_*` outputs match the request; cmd high edges +1..+10.
  - Exactly one done[0], at +12.
- **Fairness:** all 4 valid continuously, DDMA acks each after 5 cycles.
  - Grant order 0,1,2,3,0,1; no requester granted twice within 4 grants.
- **Zero size:** req 2 with size 0.
  - Grant[2] then done[2] the next cycle; `send_cmd_out` stays 0; the DDMA sees nothing.
- **Fast ack:** ack without busy ever asserted.
  - ISSUE→RELEASE→done normally.
  - A simultaneous new valid from req 3 during RELEASE is granted only after done.
- **Reset during ISSUE:** assert reset.
  - `send_cmd_out`=0 immediately; no done/error pulse.
  - After release with reqs 1 and 0 both valid, req 0 is granted first.
- **Watchdog:** macro on, `TIMEOUT_CYCLES`=100, req 1 granted, DDMA never acks.
  - error[1] pulses 100 cycles after entering ISSUE; cmd drops; no done.
  - Macro off, same stimulus: cmd still high at cycle 1000.

Source files
------------

// File: rtl/ddma_send_arbiter.sv
// rtl/ddma_send_arbiter.sv - round-robin arbiter/sequencer for the shared DDMA send channel
//
// Purpose: picks one of NUM_REQ requesters in round-robin order, latches its
// descriptor, drives the DDMA send command, waits for acknowledge and for the
// engine to go idle, then reports completion to the owning requester.
//
// Optional feature: define DDMA_ARB_TIMEOUT_EN to build a 32-bit watchdog that
// aborts a transfer stuck in ISSUE/RELEASE for TIMEOUT_CYCLES cycles and pulses
// req_error_out for the owner. Without it, req_error_out is tied to 0.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous active-low reset
//   req_valid_in   per-requester request level
//   req_dest_in    packed per-requester destination addresses
//   req_addr_in    packed per-requester source addresses
//   req_size_in    packed per-requester sizes in bytes
//   req_grant_out  one-hot pulse when a descriptor is latched
//   req_done_out   one-hot pulse on completion
//   req_error_out  one-hot pulse on watchdog expiry
//   send_dest_out / send_addr_out / send_size_out  latched descriptor to DDMA
//   send_cmd_out   send command level
//   send_busy_in   DDMA send engine not idle
//   send_ack_in    DDMA send acknowledge
//   owner_out      index of current or last granted requester
//   busy_out       high while not IDLE
module ddma_send_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int MEMORY_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid_in,
   input  logic [NUM_REQ*MEMORY_WIDTH-1:0]   req_dest_in,
   input  logic [NUM_REQ*MEMORY_WIDTH-1:0]   req_addr_in,
   input  logic [NUM_REQ*MEMORY_WIDTH-1:0]   req_size_in,
   output logic [NUM_REQ-1:0]                req_grant_out,
   output logic [NUM_REQ-1:0]                req_done_out,
   output logic [NUM_REQ-1:0]                req_error_out,
   output logic [MEMORY_WIDTH-1:0]           send_dest_out,
   output logic [MEMORY_WIDTH-1:0]           send_addr_out,
   output logic [MEMORY_WIDTH-1:0]           send_size_out,
   output logic                              send_cmd_out,
   input  logic                              send_busy_in,
   input  logic                              send_ack_in,
   output logic [$clog2(NUM_REQ)-1:0]        owner_out,
   output logic                              busy_out
);

   localparam int OW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [MEMORY_WIDTH-1:0]   dest_q, dest_d;
   logic [MEMORY_WIDTH-1:0]   addr_q, addr_d;
   logic [MEMORY_WIDTH-1:0]   size_q, size_d;
   logic [OW-1:0]             owner_q, owner_d;
   logic [OW-1:0]             last_owner_q, last_owner_d;
   logic [NUM_REQ-1:0]        grant_q, grant_d;
   logic [NUM_REQ-1:0]        done_q, done_d;
   logic                      cmd_q, cmd_d;
   // Set for the cycle after a size-0 grant; completion is reported then
   // without involving the DDMA, and no new grant is made in that cycle.
   logic                      zero_pend_q, zero_pend_d;

`ifdef DDMA_ARB_TIMEOUT_EN
   logic [31:0]               wd_q, wd_d;
   logic [NUM_REQ-1:0]        error_q, error_d;
   logic                      wd_expire;
`endif

   // Unpacked views of the packed descriptor buses.
   logic [MEMORY_WIDTH-1:0]   dest_arr [NUM_REQ];
   logic [MEMORY_WIDTH-1:0]   addr_arr [NUM_REQ];
   logic [MEMORY_WIDTH-1:0]   size_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign dest_arr[g] = req_dest_in[g*MEMORY_WIDTH +: MEMORY_WIDTH];
      assign addr_arr[g] = req_addr_in[g*MEMORY_WIDTH +: MEMORY_WIDTH];
      assign size_arr[g] = req_size_in[g*MEMORY_WIDTH +: MEMORY_WIDTH];
   end

   // Round-robin pick: first valid requester starting just after last_owner,
   // wrapping; the last candidate examined is last_owner itself.
   logic                      pick_found;
   logic [OW-1:0]             pick_idx;
   logic [OW-1:0]             cand_idx;
   int                        cand;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand     = (int'(last_owner_q) + i) % NUM_REQ;
         cand_idx = OW'(cand);
         if (!pick_found && req_valid_in[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

`ifdef DDMA_ARB_TIMEOUT_EN
   // Counter value after this cycle's increment has reached the limit.
   assign wd_expire = (wd_q + 32'd1) >= 32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d      = state_q;
      dest_d       = dest_q;
      addr_d       = addr_q;
      size_d       = size_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      grant_d      = '0;
      done_d       = '0;
      cmd_d        = cmd_q;
      zero_pend_d  = 1'b0;
`ifdef DDMA_ARB_TIMEOUT_EN
      wd_d         = wd_q;
      error_d      = '0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (zero_pend_q) begin
               done_d[owner_q] = 1'b1;
               last_owner_d    = owner_q;
            end else if (pick_found) begin
               dest_d             = dest_arr[pick_idx];
               addr_d             = addr_arr[pick_idx];
               size_d             = size_arr[pick_idx];
               owner_d            = pick_idx;
               grant_d[pick_idx]  = 1'b1;
               if (size_arr[pick_idx] != '0) begin
                  state_d = ST_ISSUE;
                  cmd_d   = 1'b1;
`ifdef DDMA_ARB_TIMEOUT_EN
                  wd_d    = '0;
`endif
               end else begin
                  zero_pend_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            // Acknowledge is accepted even if busy was never seen high.
            if (send_ack_in) begin
               cmd_d   = 1'b0;
               state_d = ST_RELEASE;
            end
`ifdef DDMA_ARB_TIMEOUT_EN
            wd_d = wd_q + 32'd1;
            if (wd_expire) begin
               cmd_d            = 1'b0;
               error_d[owner_q] = 1'b1;
               last_owner_d     = owner_q;
               state_d          = ST_IDLE;
            end
`endif
         end
         ST_RELEASE: begin
            if (!send_ack_in && !send_busy_in) begin
               done_d[owner_q] = 1'b1;
               last_owner_d    = owner_q;
               state_d         = ST_IDLE;
            end
`ifdef DDMA_ARB_TIMEOUT_EN
            else if (wd_expire) begin
               error_d[owner_q] = 1'b1;
               last_owner_d     = owner_q;
               state_d          = ST_IDLE;
            end
            wd_d = wd_q + 32'd1;
`endif
         end
         default: begin
            state_d = ST_IDLE;
            cmd_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         dest_q       <= '0;
         addr_q       <= '0;
         size_q       <= '0;
         owner_q      <= '0;
         last_owner_q <= OW'(NUM_REQ - 1);
         grant_q      <= '0;
         done_q       <= '0;
         cmd_q        <= 1'b0;
         zero_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dest_q       <= dest_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         cmd_q        <= cmd_d;
         zero_pend_q  <= zero_pend_d;
      end
   end

`ifdef DDMA_ARB_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_q    <= '0;
         error_q <= '0;
      end else begin
         wd_q    <= wd_d;
         error_q <= error_d;
      end
   end

   assign req_error_out = error_q;
`else
   // The limit only matters when the watchdog is built.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);

   assign req_error_out = '0;
`endif

   assign req_grant_out = grant_q;
   assign req_done_out  = done_q;
   assign send_dest_out = dest_q;
   assign send_addr_out = addr_q;
   assign send_size_out = size_q;
   assign send_cmd_out  = cmd_q;
   assign owner_out     = owner_q;
   assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddma_send_arbiter.sv
// tb/tb_ddma_send_arbiter.sv - scoreboard bench for ddma_send_arbiter with a round-robin reference model
module tb_ddma_send_arbiter;

   localparam int N  = 4;
   localparam int MW = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid_in;
   logic [N*MW-1:0]   req_dest_in, req_addr_in, req_size_in;
   logic [N-1:0]      req_grant_out, req_done_out, req_error_out;
   logic [MW-1:0]     send_dest_out, send_addr_out, send_size_out;
   logic              send_cmd_out, send_busy_in, send_ack_in;
   logic [1:0]        owner_out;
   logic              busy_out;

   ddma_send_arbiter #(.NUM_REQ(N), .MEMORY_WIDTH(MW), .TIMEOUT_CYCLES(100)) dut (
      .clock(clock), .reset(reset),
      .req_valid_in(req_valid_in), .req_dest_in(req_dest_in),
      .req_addr_in(req_addr_in), .req_size_in(req_size_in),
      .req_grant_out(req_grant_out), .req_done_out(req_done_out),
      .req_error_out(req_error_out),
      .send_dest_out(send_dest_out), .send_addr_out(send_addr_out),
      .send_size_out(send_size_out), .send_cmd_out(send_cmd_out),
      .send_busy_in(send_busy_in), .send_ack_in(send_ack_in),
      .owner_out(owner_out), .busy_out(busy_out)
   );

   always #5 clock = ~clock;

   // kind: 0 grant, 1 done, 2 error
   typedef struct {
      int          kind;
      int          idx;
      logic [31:0] dest;
      logic [31:0] addr;
      logic [31:0] size;
   } ev_t;

   ev_t exp_q[$];
   ev_t pend[N][$];
   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  last_grant_cyc = 0;
   int  model_last = N - 1;
   int  ddma_mode = 0;   // 0 off, 1 random, 2 never ack, 3 scripted
   int  d_fast = 0, d_ack = 0, d_len = 1, d_tail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic ev_t mk(input int idx, input logic [31:0] d, input logic [31:0] a,
                              input logic [31:0] s);
      ev_t e;
      e.kind = 0; e.idx = idx; e.dest = d; e.addr = a; e.size = s;
      return e;
   endfunction

   function automatic ev_t rnd_desc(input int idx, input bit allow_zero);
      logic [31:0] s;
      s = (allow_zero && $urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      return mk(idx, $urandom, $urandom, s);
   endfunction

   // Scoreboard monitor: every pulse must match the head of the expected queue.
   task automatic handle(input int kind, input int idx);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: kind=%0d req=%0d while nothing expected", kind, idx);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_req", idx, e.idx);
         if (kind == 0) begin
            chk("grant_dest", send_dest_out, e.dest);
            chk("grant_addr", send_addr_out, e.addr);
            chk("grant_size", send_size_out, e.size);
            chk("grant_owner", 32'(owner_out), idx);
            chk("grant_cmd", 32'(send_cmd_out), (e.size != 0) ? 32'd1 : 32'd0);
            last_grant_cyc = cyc;
         end else if (kind == 1 && e.size == 0) begin
            chk("zero_done_latency", cyc - last_grant_cyc, 1);
            chk("zero_cmd_low", 32'(send_cmd_out), 0);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (req_grant_out[i]) handle(0, i);
            if (req_done_out[i])  handle(1, i);
            if (req_error_out[i]) handle(2, i);
         end
      end
   end

   // DDMA send engine emulator.
   initial begin
      int fast, da, dl, dt;
      send_busy_in = 1'b0;
      send_ack_in  = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (reset && send_cmd_out && ddma_mode != 0) begin
            if (ddma_mode == 1) begin
               fast = ($urandom_range(0, 2) == 0) ? 1 : 0;
               da   = $urandom_range(0, 6);
               dl   = $urandom_range(1, 2);
               dt   = $urandom_range(0, 3);
            end else begin
               fast = d_fast; da = d_ack; dl = d_len; dt = d_tail;
            end
            if (ddma_mode == 2) begin
               send_busy_in = 1'b1;
               for (int k = 0; k < 3000 && reset; k++) begin
                  @(posedge clock); #1;
               end
               send_busy_in = 1'b0;
            end else begin
               if (fast == 0) send_busy_in = 1'b1;
               repeat (da) begin @(posedge clock); #1; end
               send_ack_in = 1'b1;
               repeat (dl) begin @(posedge clock); #1; end
               send_ack_in = 1'b0;
               if (fast == 0) begin
                  repeat (dt) begin @(posedge clock); #1; end
                  send_busy_in = 1'b0;
               end
            end
         end
      end
   end

   // Requester side: valid while a descriptor is pending, next one after each grant.
   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         if (pend[i].size() > 0) begin
            req_valid_in[i]          = 1'b1;
            req_dest_in[i*MW +: MW]  = pend[i][0].dest;
            req_addr_in[i*MW +: MW]  = pend[i][0].addr;
            req_size_in[i*MW +: MW]  = pend[i][0].size;
         end else begin
            req_valid_in[i] = 1'b0;
         end
      end
   endtask

   task automatic agent_step();
      @(posedge clock); #1;
      for (int i = 0; i < N; i++)
         if (req_grant_out[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      drive_reqs();
   endtask

   function automatic int pending_total();
      int t = 0;
      for (int i = 0; i < N; i++) t += pend[i].size();
      return t;
   endfunction

   // Reference model: serve pending descriptors one at a time, always choosing
   // the first requester with work after the previous owner, wrapping.
   task automatic model_push();
      int  cnt[N];
      int  pos[N];
      int  c;
      bit  any;
      ev_t e;
      for (int i = 0; i < N; i++) begin cnt[i] = pend[i].size(); pos[i] = 0; end
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         for (int j = 1; j <= N; j++) begin
            c = (model_last + j) % N;
            if (cnt[c] > 0) begin
               e = pend[c][pos[c]];
               e.idx = c; e.kind = 0; exp_q.push_back(e);
               e.kind = 1; exp_q.push_back(e);
               pos[c]++; cnt[c]--; model_last = c; any = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic agent_until_idle(input string name, input int bound);
      int n = 0;
      while ((pending_total() > 0 || exp_q.size() > 0 || busy_out) && n < bound) begin
         agent_step();
         n++;
      end
      chk(name, (n < bound) ? 32'd1 : 32'd0, 1);
   endtask

   task automatic wait_grant(input string name, input int idx);
      int n = 0;
      while (!req_grant_out[idx] && n < 5) begin agent_step(); n++; end
      chk(name, 32'(req_grant_out[idx]), 1);
   endtask

   initial begin
      ev_t e;
      int  n;
      reset = 1'b0;
      req_valid_in = '0; req_dest_in = '0; req_addr_in = '0; req_size_in = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_grant", 32'(req_grant_out), 0);
      chk("rst_done", 32'(req_done_out), 0);
      chk("rst_error", 32'(req_error_out), 0);
      chk("rst_cmd", 32'(send_cmd_out), 0);
      chk("rst_owner", 32'(owner_out), 0);
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_desc", send_dest_out | send_addr_out | send_size_out, 0);
      reset = 1'b1;
      agent_step();

      // Single request with scripted DDMA timing.
      ddma_mode = 3; d_fast = 0; d_ack = 8; d_len = 1; d_tail = 1;
      pend[0].push_back(mk(0, 32'h0101, 32'h4000_0100, 32'd16));
      model_push();
      drive_reqs();
      agent_step();
      chk("single_grant", 32'(req_grant_out), 32'b0001);
      chk("single_cmd_rise", 32'(send_cmd_out), 1);
      repeat (8) agent_step();
      chk("single_cmd_held", 32'(send_cmd_out), 1);
      agent_step();
      chk("single_cmd_drop", 32'(send_cmd_out), 0);
      agent_step();
      chk("single_no_early_done", 32'(req_done_out), 0);
      agent_step();
      chk("single_done", 32'(req_done_out), 32'b0001);
      agent_step();
      chk("single_done_pulse", 32'(req_done_out), 0);
      chk("single_idle", 32'(busy_out), 0);

      // All requesters busy: round-robin fairness.
      ddma_mode = 1;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 2; k++) pend[i].push_back(rnd_desc(i, 1'b0));
      model_push();
      drive_reqs();
      agent_until_idle("fair_complete", 2000);

      // Random rounds: random requester subsets, sizes (incl. 0), DDMA timing.
      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < N; i++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) pend[i].push_back(rnd_desc(i, 1'b1));
         end
         if (pending_total() == 0) pend[2].push_back(mk(2, $urandom, $urandom, 32'd0));
         model_push();
         drive_reqs();
         agent_until_idle("round_complete", 3000);
         repeat ($urandom_range(0, 2)) agent_step();
      end

      // DDMA that never acknowledges.
      ddma_mode = 2;
      pend[1].push_back(rnd_desc(1, 1'b0));
      e = pend[1][0]; e.idx = 1; e.kind = 0; exp_q.push_back(e);
`ifdef DDMA_ARB_TIMEOUT_EN
      e.kind = 2; exp_q.push_back(e);
`endif
      drive_reqs();
      wait_grant("hang_grant", 1);
`ifdef DDMA_ARB_TIMEOUT_EN
      n = 0;
      while (!req_error_out[1] && n < 300) begin agent_step(); n++; end
      chk("wd_error_delay", n, 100);
      chk("wd_cmd_drop", 32'(send_cmd_out), 0);
      chk("wd_idle", 32'(busy_out), 0);
      model_last = 1;
      pend[2].push_back(rnd_desc(2, 1'b0));
      e = pend[2][0]; e.idx = 2; e.kind = 0; exp_q.push_back(e);
      drive_reqs();
      wait_grant("wd_next_grant", 2);
      repeat (5) agent_step();
`else
      repeat (1000) agent_step();
      chk("nowd_cmd_high", 32'(send_cmd_out), 1);
      chk("nowd_busy", 32'(busy_out), 1);
      chk("nowd_no_error", 32'(req_error_out), 0);
`endif

      // Reset in the middle of ISSUE.
      #3;
      reset = 1'b0;
      #1;
      chk("rst_mid_cmd_async", 32'(send_cmd_out), 0);
      chk("rst_mid_busy", 32'(busy_out), 0);
      req_valid_in = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_mid_no_pulse", 32'(req_done_out | req_error_out | req_grant_out), 0);
      chk("rst_mid_queue_empty", exp_q.size(), 0);
      ddma_mode = 1;
      model_last = N - 1;
      reset = 1'b1;
      pend[1].push_back(rnd_desc(1, 1'b0));
      pend[0].push_back(rnd_desc(0, 1'b0));
      model_push();
      drive_reqs();
      agent_step();
      chk("rst_after_first_grant", 32'(req_grant_out), 32'b0001);
      agent_until_idle("rst_after_complete", 2000);

      repeat (3) agent_step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL global_timeout: simulation did not complete in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "global timeout");
   end

endmodule
